// File: rtl/gsim_matvec_if.sv
// Stream bundle for gsim_matvec: Q16.16 x elements in, integer b elements out.
// The master drives x and receives b; the engine sits on the slave side.
interface gsim_matvec_if;
    logic        in_en;
    logic [31:0] x_in;
    logic        out_valid;
    logic [15:0] b_out;

    modport master (
        output in_en,
        output x_in,
        input  out_valid,
        input  b_out
    );

    modport slave (
        input  in_en,
        input  x_in,
        output out_valid,
        output b_out
    );
endinterface

// File: rtl/gsim_matvec.sv
// Banded matrix-vector engine: b = A*x for the solver's fixed 16x16 heptadiagonal
// matrix (row taps -1, 6, -13, 20, -13, 6, -1). Loads 16 Q16.16 elements, then
// streams 16 rounded integer results, one per cycle.
// Optional: define GSIM_MATVEC_SAT_EN to clamp results to int16 instead of wrapping.
module gsim_matvec #(
    parameter int unsigned N     = 16,
    parameter int unsigned ACC_W = 38
) (
    input logic          clk,
    input logic          reset,
    gsim_matvec_if.slave mv
);

    localparam int unsigned IdxW = $clog2(N);
    localparam logic [IdxW-1:0] Last = IdxW'(N - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StCalc} state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic                  out_valid_q, out_valid_d;
    logic [15:0]           b_q, b_d;
    logic [31:0]           x_q [N];
    logic                  x_we;
    logic [IdxW-1:0]       x_waddr;

    logic signed [ACC_W-1:0] tap [7];
    logic signed [ACC_W-1:0] s1, s2, s3, acc, sum, rnd;
    logic [15:0]             b_row;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: load 16 elements (gaps allowed), then emit 16 rows.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (mv.in_en) state_d = StLoad;
            StLoad: if (mv.in_en && cnt_q == Last) state_d = StCalc;
            StCalc: if (idx_q == Last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // 7-tap window around row idx; taps outside 0..N-1 read as zero.
    always_comb begin
        for (int k = 0; k < 7; k++) begin
            int pos;
            pos = int'(idx_q) + k - 3;
            tap[k] = '0;
            if (pos >= 0 && pos < int'(N)) begin
                tap[k] = {{(ACC_W-32){x_q[pos[IdxW-1:0]][31]}}, x_q[pos[IdxW-1:0]]};
            end
        end
    end

    // Row dot product with shift/add constant multiplies, then round half up.
    always_comb begin
        s1  = tap[2] + tap[4];
        s2  = tap[1] + tap[5];
        s3  = tap[0] + tap[6];
        acc = (tap[3] <<< 4) + (tap[3] <<< 2)
            - ((s1 <<< 3) + (s1 <<< 2) + s1)
            + ((s2 <<< 2) + (s2 <<< 1))
            - s3;
        sum = acc + ACC_W'(32768);
        rnd = sum >>> 16;
    end

`ifdef GSIM_MATVEC_SAT_EN
    localparam logic signed [ACC_W-1:0] MaxB = 32767;
    localparam logic signed [ACC_W-1:0] MinB = -32768;

    // Clamp the rounded row result into int16 range.
    always_comb begin
        if (rnd > MaxB) begin
            b_row = 16'h7fff;
        end else if (rnd < MinB) begin
            b_row = 16'h8000;
        end else begin
            b_row = rnd[15:0];
        end
    end
`else
    logic unused_rnd;
    assign unused_rnd = ^rnd[ACC_W-1:16];

    // Two's-complement wrap: keep the low 16 bits of the rounded result.
    always_comb begin
        b_row = rnd[15:0];
    end
`endif

    // Per-state datapath updates: buffer writes, counters and output register.
    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        b_d         = b_q;
        x_we        = 1'b0;
        x_waddr     = cnt_q;
        case (state_q)
            StIdle: begin
                out_valid_d = 1'b0;
                if (mv.in_en) begin
                    x_we    = 1'b1;
                    x_waddr = '0;
                    cnt_d   = IdxW'(1);
                end
            end
            StLoad: begin
                if (mv.in_en) begin
                    x_we  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == Last) begin
                        cnt_d = '0;
                        idx_d = '0;
                    end
                end
            end
            StCalc: begin
                b_d         = b_row;
                out_valid_d = 1'b1;
                idx_d       = idx_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            b_q         <= '0;
            for (int i = 0; i < int'(N); i++) begin
                x_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            b_q         <= b_d;
            if (x_we) begin
                x_q[x_waddr] <= mv.x_in;
            end
        end
    end

    assign mv.out_valid = out_valid_q;
    assign mv.b_out     = b_q;

endmodule

// File: tb/tb_gsim_matvec.sv
// Self-checking bench for gsim_matvec: directed and random frames against an
// arithmetic reference of b = A*x with round-half-up to integer.
module tb_gsim_matvec;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    gsim_matvec_if mv ();

    gsim_matvec dut (
        .clk   (clk),
        .reset (reset),
        .mv    (mv)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] fx [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference row i (0-based) from the matrix definition.
    function automatic logic [15:0] model_b(input int i);
        int     coef [7] = '{-1, 6, -13, 20, -13, 6, -1};
        longint acc = 0;
        longint r;
        for (int d = -3; d <= 3; d++) begin
            int j = i + d;
            if (j >= 0 && j < 16) begin
                longint v = longint'($signed(fx[j]));
                acc += longint'(coef[d + 3]) * v;
            end
        end
        r = (acc + 64'sd32768) >>> 16;
`ifdef GSIM_MATVEC_SAT_EN
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load fx (random gaps up to max_gap), then check the 16 output cycles.
    task automatic send_frame(input int max_gap, input bit junk_in_calc);
        logic [15:0] exp [16];
        for (int i = 0; i < 16; i++) exp[i] = model_b(i);
        for (int i = 0; i < 16; i++) begin
            int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            mv.in_en = 1'b0;
            repeat (gap) begin
                tick();
                check("gap_valid", 32'(mv.out_valid), 32'd0);
            end
            mv.in_en = 1'b1;
            mv.x_in  = fx[i];
            tick();
            check("load_valid", 32'(mv.out_valid), 32'd0);
        end
        for (int r = 0; r < 16; r++) begin
            mv.in_en = junk_in_calc;
            mv.x_in  = $urandom;
            tick();
            check($sformatf("valid[%0d]", r + 1), 32'(mv.out_valid), 32'd1);
            check($sformatf("b[%0d]", r + 1), 32'(mv.b_out), 32'(exp[r]));
        end
        mv.in_en = 1'b0;
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < 16; i++) fx[i] = v;
    endtask

    initial begin
        reset    = 1'b1;
        mv.in_en = 1'b0;
        mv.x_in  = '0;
        repeat (3) tick();
        check("rst_valid", 32'(mv.out_valid), 32'd0);
        check("rst_b", 32'(mv.b_out), 32'd0);
        reset = 1'b0;
        tick();

        // All ones, then back-to-back impulse at x_5.
        fill(32'h0001_0000);
        send_frame(0, 1'b0);
        fill(32'h0);
        fx[4] = 32'h0001_0000;
        send_frame(0, 1'b0);

        // Rounding: x_1 = 0.5.
        fill(32'h0);
        fx[0] = 32'h0000_8000;
        send_frame(0, 1'b0);

        // Overflow and large negative inputs.
        fill(32'h7fff_ffff);
        send_frame(0, 1'b0);
        fill(32'h8000_0000);
        send_frame(0, 1'b0);

        // Gapped load must match the gap-free result.
        fill(32'h0001_0000);
        send_frame(3, 1'b0);

        // Random frames: small and full-range values, gaps, in_en noise during output.
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 16; i++) begin
                if (f[0]) fx[i] = $urandom;
                else fx[i] = $urandom_range(32'h0008_0000, 0) - 32'h0004_0000;
            end
            send_frame(f % 4, f[1]);
        end

        // Aborted frame: 9 samples, reset, then a full frame of ones.
        for (int i = 0; i < 9; i++) begin
            mv.in_en = 1'b1;
            mv.x_in  = $urandom;
            tick();
            check("abort_valid", 32'(mv.out_valid), 32'd0);
        end
        mv.in_en = 1'b0;
        reset    = 1'b1;
        #1;
        check("mid_rst_valid", 32'(mv.out_valid), 32'd0);
        check("mid_rst_b", 32'(mv.b_out), 32'd0);
        tick();
        check("mid_rst_valid2", 32'(mv.out_valid), 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_valid", 32'(mv.out_valid), 32'd0);
        fill(32'h0001_0000);
        send_frame(0, 1'b0);

        tick();
        check("final_idle", 32'(mv.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
